elastic_pipe: RTL and testbench
===============================

# elastic_pipe

Parametrised elastic pipeline register chain with a valid/ready handshake, synchronous flush and an occupancy count. It generalises the fixed, never-stalling pipeline register used between processor stages (IF→OF, OF→EX, EX→MEM, MEM→WB). Hazard and branch logic can use it to stall or squash any stage boundary without losing or duplicating packets. Callers pack stage structs into the data vector using `$bits` of the packet type.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `DEPTH`, 1: number of register stages in the chain (1..8).
- `SKID`, 1: 1 = each stage holds a main register plus a skid register, with a registered `in_ready`; 0 = single register per stage, with `ready` chained combinationally.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream item present.
- `in_ready`  out  1  chain can accept an item this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  head item present.
- `out_ready`  in  1  downstream accepts the head item.
- `out_data`  out  WIDTH  head payload.
- `occupancy`  out  `$clog2(CAP+1)`  number of valid entries held, where CAP = DEPTH·(1+SKID).

## Operation
- **Transfer rule.** A transfer occurs on any edge where valid && ready at a boundary.
  - Items leave in exact acceptance order, with no loss and no duplication.
- **Per stage, SKID=1.**
  - Ready to upstream is `!skid_valid`, which is a registered signal.
  - An incoming item goes to main if main is empty, or if main drains in the same cycle; otherwise it goes to skid.
  - When main drains and skid is valid, skid moves into main on the same edge.
- **Per stage, SKID=0.** Ready is `!valid || downstream_ready`. This is a combinational path through all DEPTH stages.
- **Occupancy.** `occupancy` = count of set valid bits, registered.
  - Increment on an accepted input, decrement on an accepted output.
  - Both in the same cycle leaves it unchanged.
- **Flush.**
  - While `flush`=1, `in_ready`=0, so nothing is accepted.
  - An output handshake in the flush cycle completes normally and is counted as delivered.
  - On that edge every valid bit clears and `occupancy` becomes 0.
- **Full.** When `occupancy`=CAP and `out_ready`=0, `in_ready`=0. Upstream must hold `in_data` stable while `in_valid`=1.
- **Empty.** `out_valid`=0; `out_data` is don't-care but holds its last value.
- **Reset.**
  - All valid bits, skid bits, data registers and `occupancy` go to 0 immediately, including mid-transfer.
  - `out_valid`=0 and `out_data`=0.
  - `in_ready`=0 while reset is asserted; it becomes 1 on the first edge after release.

## Timing
- **Latency (empty chain).** An item accepted at edge N is presented with `out_valid`=1 after edge N+DEPTH−1 completes, i.e. visible for the handshake at edge N+DEPTH.
- **Throughput.** 1 item per cycle sustained for both SKID settings when `out_ready`=1.
- **Capacity.** CAP items when `out_ready` is held low (DEPTH·2 for SKID=1, DEPTH for SKID=0).
- **`in_ready` timing.**
  - SKID=1: `in_ready` depends only on registers and `flush`.
  - SKID=0: `in_ready` may depend combinationally on `out_ready`.
- **No handshake deadlock.**
  - A valid source must not wait on ready.
  - `out_valid`, once asserted, stays asserted until accepted, unless `flush` or `reset` occurs.

## Structure
- Sub-module `elastic_stage` (WIDTH, SKID) contains one main register, an optional skid register and the ready/valid logic. `elastic_pipe` generates DEPTH instances and the occupancy counter.
- No new typedefs. Add the helper constant `ELASTIC_MAX_DEPTH = 8` to `rv32_pkg`, and check it with an elaboration-time assertion on DEPTH.
- Stage boundaries in the processor top instantiate it as `elastic_pipe #(.WIDTH($bits(rv32_issue_packet_t)))`, with struct casts at both ends.

## Test plan
- **Streaming latency.** DEPTH=3, SKID=1, `out_ready`=1; drive 0x01..0x10 back-to-back → first `out_valid` on the 3rd cycle after the first accept; 16 items out in order with no gaps; `occupancy` steady at 3.
- **Backpressure, SKID=1.** DEPTH=3, SKID=1; `out_ready`=0 for 10 cycles with `in_valid`=1 → exactly 6 accepted, `in_ready`=0, `occupancy`=6; release → 0x01..0x06 then the rest, none lost or duplicated.
- **Backpressure, SKID=0.** DEPTH=2, SKID=0, full, `out_ready` toggling 1/0 each cycle → `in_ready` mirrors `out_ready` in the same cycle; capacity 2; order preserved.
- **Flush.** `occupancy`=4, head 0xA5 with `out_ready`=1, `flush`=1, `in_valid`=1 with data 0x77 → 0xA5 delivered; next cycle `occupancy`=0 and `out_valid`=0; 0x77 is never output.
- **Reset mid-stream.** Assert `reset` between edges during streaming → `out_valid`, `in_ready`, `occupancy`=0 without waiting for an edge; after release the chain restarts empty.
- **Random soak.** Random `in_valid`/`out_ready` (50%) and 2% `flush`, 10k items, all DEPTH 1..8 × SKID 0/1 → scoreboard matches; `occupancy` never exceeds CAP and equals the scoreboard count every cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared constants for the rv32 pipeline; elastic_pipe bounds its DEPTH against these.
package rv32_pkg;

  localparam int ELASTIC_MAX_DEPTH = 8;

endpackage

// File: rtl/elastic_stage.sv
// One elastic register stage: main register, optional skid register, valid/ready logic.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module elastic_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;

  assign out_valid = main_valid;
  assign out_data  = main_data;

  if (SKID != 0) begin : g_skid
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             main_free;

    // Ready is purely registered, which breaks the combinational ready chain.
    assign in_ready  = !skid_valid;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= in_valid;
          if (in_valid) main_data <= in_data;
        end
      end else if (in_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end else begin : g_plain
    assign in_ready = !main_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (in_ready) begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline register chain of DEPTH stages with flush and a registered occupancy count.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module elastic_pipe
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter int SKID  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      out_data,
  output logic [$clog2(DEPTH*(1+SKID)+1)-1:0]   occupancy
);

  localparam int CAP   = DEPTH * (1 + SKID);
  localparam int OCC_W = $clog2(CAP + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  if (DEPTH < 1 || DEPTH > ELASTIC_MAX_DEPTH || WIDTH < 1 || SKID < 0 || SKID > 1) begin : g_param_check
    $error("elastic_pipe: unsupported parameters DEPTH=%0d WIDTH=%0d SKID=%0d", DEPTH, WIDTH, SKID);
  end

  // Held low through reset and released on the first edge afterwards.
  logic             accept_en;
  logic [OCC_W-1:0] occ;
  logic             acc_in;
  logic             acc_out;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             s_in_valid;
    logic             s_in_ready;
    logic [WIDTH-1:0] s_in_data;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [WIDTH-1:0] s_out_data;

    if (i == 0) begin : g_head
      assign s_in_valid = in_valid && accept_en && !flush;
      assign s_in_data  = in_data;
    end else begin : g_link
      assign s_in_valid = g_stage[i-1].s_out_valid;
      assign s_in_data  = g_stage[i-1].s_out_data;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign s_out_ready = out_ready;
    end else begin : g_mid
      assign s_out_ready = g_stage[i+1].s_in_ready;
    end

    elastic_stage #(.WIDTH(WIDTH), .SKID(SKID)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data)
    );
  end

  assign in_ready  = accept_en && !flush && g_stage[0].s_in_ready;
  assign out_valid = g_stage[DEPTH-1].s_out_valid;
  assign out_data  = g_stage[DEPTH-1].s_out_data;
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;
  assign occupancy = occ;

  // An output handshake during flush still completes; the count then restarts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_en <= 1'b0;
      occ       <= '0;
    end else begin
      accept_en <= 1'b1;
      if (flush) begin
        occ <= '0;
      end else begin
        case ({acc_in, acc_out})
          2'b10:   occ <= occ + OCC_ONE;
          2'b01:   occ <= occ - OCC_ONE;
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and randomized bench for elastic_pipe: DEPTH=3/SKID=1 and DEPTH=2/SKID=0 side by side.
module tb_elastic_pipe;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic [2:0] occ_a;
  logic [1:0] occ_b;
  logic [3:0] occ_v     [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_mode = 0;
  int rdy_mode = 0;
  bit flush_rand = 0;

  logic       acc_in_last [2];
  logic [7:0] nxt         [2];
  int         acc_cnt     [2];
  int         out_cnt     [2];
  int         acc_cyc     [2];
  int         first_valid [2];
  logic       prev_valid  [2];
  logic       prev_hs     [2];
  logic [7:0] prev_data   [2];
  logic       prev_flush;

  elastic_pipe #(.WIDTH(8), .DEPTH(3), .SKID(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0]),
    .occupancy (occ_a)
  );

  elastic_pipe #(.WIDTH(8), .DEPTH(2), .SKID(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1]),
    .occupancy (occ_b)
  );

  assign occ_v[0] = {1'b0, occ_a};
  assign occ_v[1] = {2'b00, occ_b};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic int skd(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int cap(int k);
    return dep(k) * (1 + skd(k));
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] q_front(int k);
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int k);
    if (k == 0) void'(exp_q0.pop_front());
    else void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int k, input logic [7:0] v);
    if (k == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic q_clear();
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compares the settled outputs against the reference queue, then applies the coming edge.
  task automatic monitor();
    int   n;
    logic ai;
    logic ao;
    for (int k = 0; k < 2; k++) begin
      n = q_size(k);
      check($sformatf("occupancy[%0d]", k), 32'(occ_v[k]), n);
      check($sformatf("occ_within_cap[%0d]", k), 32'(occ_v[k] <= 4'(cap(k))), 1);
      if (flush) check($sformatf("in_ready_flush[%0d]", k), 32'(in_ready[k]), 0);
      else if (n == 0) check($sformatf("in_ready_empty[%0d]", k), 32'(in_ready[k]), 1);
      if (n == cap(k) && !out_ready[k]) check($sformatf("in_ready_full[%0d]", k), 32'(in_ready[k]), 0);
      if (skd(k) == 0 && n == cap(k) && !flush)
        check($sformatf("in_ready_mirror[%0d]", k), 32'(in_ready[k]), 32'(out_ready[k]));
      if (n == 0) check($sformatf("out_valid_empty[%0d]", k), 32'(out_valid[k]), 0);
      else if (out_valid[k] === 1'b1) check($sformatf("out_data_order[%0d]", k), 32'(out_data[k]), 32'(q_front(k)));
      if (prev_valid[k] && !prev_hs[k] && !prev_flush) begin
        check($sformatf("out_valid_hold[%0d]", k), 32'(out_valid[k]), 1);
        check($sformatf("out_data_hold[%0d]", k), 32'(out_data[k]), 32'(prev_data[k]));
      end
      if (out_valid[k] === 1'b1 && first_valid[k] < 0) first_valid[k] = cyc;
      ai = (in_valid[k] === 1'b1) && (in_ready[k] === 1'b1);
      ao = (out_valid[k] === 1'b1) && (out_ready[k] === 1'b1);
      if (ao) begin
        if (n > 0) q_pop(k);
        out_cnt[k]++;
      end
      if (flush) begin
        if (k == 0) exp_q0.delete();
        else exp_q1.delete();
      end else if (ai) begin
        q_push(k, in_data[k]);
        acc_cnt[k]++;
        acc_cyc[k] = cyc;
      end
      acc_in_last[k] = ai;
      prev_valid[k]  = (out_valid[k] === 1'b1);
      prev_hs[k]     = ao;
      prev_data[k]   = out_data[k];
    end
    prev_flush = flush;
    cyc++;
  endtask

  // Driver: new payload only after acceptance, so in_data is stable while in_valid is held.
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (acc_in_last[k]) begin
        in_data[k] = nxt[k];
        nxt[k]     = nxt[k] + 8'd1;
      end
      case (src_mode)
        0: in_valid[k] = 1'b0;
        1: in_valid[k] = 1'b1;
        default: if (!in_valid[k] || acc_in_last[k]) in_valid[k] = ($urandom_range(0, 1) == 1);
      endcase
      case (rdy_mode)
        0: out_ready[k] = 1'b0;
        1: out_ready[k] = 1'b1;
        2: out_ready[k] = ($urandom_range(0, 1) == 1);
        default: out_ready[k] = ~out_ready[k];
      endcase
    end
    if (flush_rand) flush = ($urandom_range(0, 99) < 2);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 2; k++) begin
      acc_in_last[k] = 1'b0;
      prev_valid[k]  = 1'b0;
      prev_hs[k]     = 1'b0;
    end
    prev_flush = 1'b0;
  endtask

  task automatic set_inputs(input logic v, input logic r);
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = v;
      out_ready[k] = r;
    end
  endtask

  initial begin
    int a0 [2];
    int o0 [2];

    reset = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_data[k]     = 8'h01;
      nxt[k]         = 8'h02;
      acc_cnt[k]     = 0;
      out_cnt[k]     = 0;
      acc_cyc[k]     = 0;
      first_valid[k] = -1;
      prev_data[k]   = '0;
    end
    set_inputs(1'b0, 1'b0);
    clear_hist();

    // Reset values, and in_ready held low until the first edge after release
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), 32'(out_valid[k]), 0);
      check($sformatf("rst_out_data[%0d]", k), 32'(out_data[k]), 0);
      check($sformatf("rst_in_ready[%0d]", k), 32'(in_ready[k]), 0);
      check($sformatf("rst_occ[%0d]", k), 32'(occ_v[k]), 0);
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("rel_in_ready_low[%0d]", k), 32'(in_ready[k]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("rel_in_ready_high[%0d]", k), 32'(in_ready[k]), 1);

    // Latency of a single item through an empty chain
    rdy_mode = 1;
    src_mode = 0;
    set_inputs(1'b1, 1'b1);
    tick();
    repeat (10) tick();
    for (int k = 0; k < 2; k++)
      check($sformatf("latency[%0d]", k), first_valid[k] - acc_cyc[k], dep(k));

    // Back-to-back streaming with out_ready high
    src_mode = 1;
    set_inputs(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin a0[k] = acc_cnt[k]; o0[k] = out_cnt[k]; end
    repeat (20) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stream_in[%0d]", k), acc_cnt[k] - a0[k], 20);
      check($sformatf("stream_out[%0d]", k), out_cnt[k] - o0[k], 20 - dep(k));
      check($sformatf("stream_occ[%0d]", k), 32'(occ_v[k]), dep(k));
    end
    src_mode = 0;
    set_inputs(1'b0, 1'b1);
    repeat (6) tick();

    // Backpressure: capacity, in_ready timing, then toggling out_ready
    rdy_mode = 0;
    src_mode = 1;
    set_inputs(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) a0[k] = acc_cnt[k];
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bp_accepted[%0d]", k), acc_cnt[k] - a0[k], cap(k));
      check($sformatf("bp_in_ready[%0d]", k), 32'(in_ready[k]), 0);
      check($sformatf("bp_occ[%0d]", k), 32'(occ_v[k]), cap(k));
    end
    for (int k = 0; k < 2; k++) out_ready[k] = 1'b1;
    #1;
    check("skid_ready_registered", 32'(in_ready[0]), 0);
    check("plain_ready_comb", 32'(in_ready[1]), 1);
    for (int k = 0; k < 2; k++) out_ready[k] = 1'b0;
    #1;
    rdy_mode = 3;
    for (int k = 0; k < 2; k++) begin a0[k] = acc_cnt[k]; o0[k] = out_cnt[k]; end
    repeat (10) tick();
    check("toggle_out", out_cnt[1] - o0[1], 5);
    check("toggle_in", acc_cnt[1] - a0[1], 5);
    rdy_mode = 1;
    src_mode = 0;
    set_inputs(1'b0, 1'b1);
    repeat (12) tick();
    for (int k = 0; k < 2; k++) check($sformatf("bp_drained[%0d]", k), q_size(k), 0);

    // Flush with a head handshake in the same cycle
    rdy_mode = 0;
    src_mode = 1;
    set_inputs(1'b1, 1'b0);
    repeat (4) tick();
    check("flush_pre_occ_a", 32'(occ_v[0]), 4);
    check("flush_pre_occ_b", 32'(occ_v[1]), 2);
    rdy_mode = 1;
    for (int k = 0; k < 2; k++) begin out_ready[k] = 1'b1; o0[k] = out_cnt[k]; a0[k] = acc_cnt[k]; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_mode = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = nxt[k];
      nxt[k]      = nxt[k] + 8'd1;
      check($sformatf("flush_delivered[%0d]", k), out_cnt[k] - o0[k], 1);
      check($sformatf("flush_no_accept[%0d]", k), acc_cnt[k] - a0[k], 0);
      check($sformatf("flush_occ[%0d]", k), 32'(occ_v[k]), 0);
      check($sformatf("flush_out_valid[%0d]", k), 32'(out_valid[k]), 0);
    end
    repeat (4) tick();

    // Reset asserted between edges during streaming
    src_mode = 1;
    rdy_mode = 2;
    set_inputs(1'b1, 1'b1);
    repeat (8) tick();
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_out_valid[%0d]", k), 32'(out_valid[k]), 0);
      check($sformatf("midrst_in_ready[%0d]", k), 32'(in_ready[k]), 0);
      check($sformatf("midrst_occ[%0d]", k), 32'(occ_v[k]), 0);
      check($sformatf("midrst_out_data[%0d]", k), 32'(out_data[k]), 0);
    end
    q_clear();
    clear_hist();
    src_mode = 0;
    set_inputs(1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("midrst_rel_low[%0d]", k), 32'(in_ready[k]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_rel_high[%0d]", k), 32'(in_ready[k]), 1);
      check($sformatf("midrst_rel_occ[%0d]", k), 32'(occ_v[k]), 0);
    end

    // Random soak with occasional flush
    src_mode = 2;
    rdy_mode = 2;
    flush_rand = 1'b1;
    for (int k = 0; k < 2; k++) o0[k] = out_cnt[k];
    repeat (3000) tick();
    flush_rand = 1'b0;
    flush = 1'b0;
    src_mode = 0;
    rdy_mode = 1;
    set_inputs(1'b0, 1'b1);
    repeat (20) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("soak_progress[%0d]", k), 32'(out_cnt[k] - o0[k] > 500), 1);
      check($sformatf("soak_drained[%0d]", k), q_size(k), 0);
      check($sformatf("soak_occ[%0d]", k), 32'(occ_v[k]), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
